mem_arbiter: RTL and testbench

//  Two-master to one-slave arbiter between the I-cache and D-cache controllers and physical memory.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (I-cache, D-cache) to one-slave (memory) line arbiter.
// One master is granted at a time. Its request is forwarded to the memory port, and
// ack/retry are routed back to it. Read data goes to both masters in parallel.
// Optional build macro MEM_ARB_RR_EN:
//   defined   -> round-robin tie-break (the master that was not granted last wins)
//   undefined -> fixed priority, the D-side wins a tie
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no grant, memory port quiet, picks a winner for next cycle
// GRANT_I | I-cache owns the memory port until completion or abort
// GRANT_D | D-cache owns the memory port until completion or abort
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int SEL_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_adr,
    input  logic [LINE_W-1:0] i_dat_w,
    input  logic [SEL_W-1:0]  i_sel,
    output logic              i_ack,
    output logic              i_retry,
    output logic [LINE_W-1:0] i_dat_r,
    input  logic              d_cyc,
    input  logic              d_stb,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [LINE_W-1:0] d_dat_w,
    input  logic [SEL_W-1:0]  d_sel,
    output logic              d_ack,
    output logic              d_retry,
    output logic [LINE_W-1:0] d_dat_r,
    output logic              m_cyc,
    output logic              m_stb,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_adr,
    output logic [LINE_W-1:0] m_dat_w,
    output logic [SEL_W-1:0]  m_sel,
    input  logic              m_ack,
    input  logic              m_retry,
    input  logic [LINE_W-1:0] m_dat_r
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t state;
    logic   last_grant_d;   // 1: D-side completed last, 0: I-side completed last
    logic   req_i;
    logic   req_d;
    logic   done;
    logic   pick_d;

    assign req_i = i_cyc & i_stb;
    assign req_d = d_cyc & d_stb;
    assign done  = m_ack & ~m_retry;

`ifdef MEM_ARB_RR_EN
    // A lone D request wins. On a tie, D wins only if I completed last.
    assign pick_d = req_d & (~req_i | ~last_grant_d);
`else
    // D always wins a tie. last_grant is still kept up to date, but nothing reads it.
    logic unused_last_grant;
    assign pick_d = req_d;
    assign unused_last_grant = last_grant_d;
`endif

    // Grant state machine and record of who completed last.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d)
                        state <= GRANT_D;
                    else if (req_i)
                        state <= GRANT_I;
                end
                GRANT_I: begin
                    if (!req_i) begin
                        state <= IDLE;
                    end else if (done) begin
                        state        <= IDLE;
                        last_grant_d <= 1'b0;
                    end
                end
                GRANT_D: begin
                    if (!req_d) begin
                        state <= IDLE;
                    end else if (done) begin
                        state        <= IDLE;
                        last_grant_d <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory port mux and ack/retry routing. Ack is gated with the request so that
    // a master that has dropped its request is never acknowledged.
    always_comb begin
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        m_we    = 1'b0;
        m_adr   = '0;
        m_dat_w = '0;
        m_sel   = '0;
        i_ack   = 1'b0;
        i_retry = 1'b0;
        d_ack   = 1'b0;
        d_retry = 1'b0;
        case (state)
            GRANT_I: begin
                m_cyc   = i_cyc & req_i;
                m_stb   = i_stb & req_i;
                m_we    = i_we;
                m_adr   = i_adr;
                m_dat_w = i_dat_w;
                m_sel   = i_sel;
                i_ack   = done & req_i;
                i_retry = m_retry;
            end
            GRANT_D: begin
                m_cyc   = d_cyc & req_d;
                m_stb   = d_stb & req_d;
                m_we    = d_we;
                m_adr   = d_adr;
                m_dat_w = d_dat_w;
                m_sel   = d_sel;
                d_ack   = done & req_d;
                d_retry = m_retry;
            end
            default: ;
        endcase
    end

    // Read data goes to both masters; each one takes it only when its ack is high.
    assign i_dat_r = m_dat_r;
    assign d_dat_r = m_dat_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs change on the falling edge, and outputs
// are sampled 1 ns later. The expected values are worked out by hand from the
// arbitration rules.
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;
    localparam int SEL_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_cyc, i_stb, i_we;
    logic [ADDR_W-1:0] i_adr;
    logic [LINE_W-1:0] i_dat_w;
    logic [SEL_W-1:0]  i_sel;
    logic              i_ack, i_retry;
    logic [LINE_W-1:0] i_dat_r;
    logic              d_cyc, d_stb, d_we;
    logic [ADDR_W-1:0] d_adr;
    logic [LINE_W-1:0] d_dat_w;
    logic [SEL_W-1:0]  d_sel;
    logic              d_ack, d_retry;
    logic [LINE_W-1:0] d_dat_r;
    logic              m_cyc, m_stb, m_we;
    logic [ADDR_W-1:0] m_adr;
    logic [LINE_W-1:0] m_dat_w;
    logic [SEL_W-1:0]  m_sel;
    logic              m_ack, m_retry;
    logic [LINE_W-1:0] m_dat_r;

    int total = 0;
    int bad   = 0;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr),
        .i_dat_w(i_dat_w), .i_sel(i_sel), .i_ack(i_ack), .i_retry(i_retry),
        .i_dat_r(i_dat_r),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr),
        .d_dat_w(d_dat_w), .d_sel(d_sel), .d_ack(d_ack), .d_retry(d_retry),
        .d_dat_r(d_dat_r),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel), .m_ack(m_ack), .m_retry(m_retry),
        .m_dat_r(m_dat_r)
    );

    task automatic clr();
        i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_dat_w = '0; i_sel = '0;
        d_cyc = 0; d_stb = 0; d_we = 0; d_adr = '0; d_dat_w = '0; d_sel = '0;
        m_ack = 0; m_retry = 0; m_dat_r = '0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [LINE_W-1:0] pat;
        pat = {4{32'hA5A5_0F0F}};
        clr();
        rst = 1'b1;
        i_cyc = 1; i_stb = 1; i_adr = 16'h0ABC;
        m_ack = 1; m_dat_r = pat;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if ({m_cyc, m_stb, m_we} !== 3'b000) begin
            bad++; $display("FAIL reset_m_ctl: got %b want 000", {m_cyc, m_stb, m_we});
        end
        total++;
        if (m_adr !== '0 || m_sel !== '0 || m_dat_w !== '0) begin
            bad++; $display("FAIL reset_m_data: adr %h sel %h want 0", m_adr, m_sel);
        end
        total++;
        if ({i_ack, i_retry, d_ack, d_retry} !== 4'b0000) begin
            bad++; $display("FAIL reset_acks: got %b want 0000", {i_ack, i_retry, d_ack, d_retry});
        end
        total++;
        if (i_dat_r !== pat || d_dat_r !== pat) begin
            bad++; $display("FAIL reset_dat_r: got %h want %h", i_dat_r, pat);
        end
        rst = 1'b0;
        clr();
    endtask

    task automatic test_single_read();
        logic [LINE_W-1:0] line;
        line = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
        do_reset();
        i_cyc = 1; i_stb = 1; i_we = 0; i_adr = 16'h1230; i_sel = 16'hFFFF;
        #1;
        total++;
        if (m_cyc !== 1'b0) begin bad++; $display("FAIL t1_cyc1_idle: m_cyc got %b want 0", m_cyc); end
        @(negedge clk); #1;
        total++;
        if ({m_cyc, m_stb, m_we} !== 3'b110) begin
            bad++; $display("FAIL t1_cyc2_grant: cyc/stb/we got %b want 110", {m_cyc, m_stb, m_we});
        end
        total++;
        if (m_adr !== 16'h1230) begin bad++; $display("FAIL t1_cyc2_adr: got %h want 1230", m_adr); end
        @(negedge clk); #1;
        total++;
        if (i_ack !== 1'b0 || m_cyc !== 1'b1) begin
            bad++; $display("FAIL t1_cyc3_wait: i_ack %b m_cyc %b want 0 1", i_ack, m_cyc);
        end
        @(negedge clk);
        m_ack = 1; m_dat_r = line;
        #1;
        total++;
        if (i_ack !== 1'b1 || d_ack !== 1'b0) begin
            bad++; $display("FAIL t1_cyc4_ack: i_ack %b d_ack %b want 1 0", i_ack, d_ack);
        end
        total++;
        if (i_dat_r !== line) begin bad++; $display("FAIL t1_cyc4_data: got %h want %h", i_dat_r, line); end
        @(negedge clk);
        clr();
        #1;
        total++;
        if (m_cyc !== 1'b0 || i_ack !== 1'b0) begin
            bad++; $display("FAIL t1_cyc5_idle: m_cyc %b i_ack %b want 0 0", m_cyc, i_ack);
        end
        m_ack = 1;
        #1;
        total++;
        if (i_ack !== 1'b0 || d_ack !== 1'b0) begin
            bad++; $display("FAIL idle_ack_ignored: i_ack %b d_ack %b want 0 0", i_ack, d_ack);
        end
        @(negedge clk); #1;
        total++;
        if (m_cyc !== 1'b0) begin bad++; $display("FAIL idle_ack_stays: m_cyc got %b want 0", m_cyc); end
        clr();
    endtask

    task automatic test_tie();
        bit first_d;
        first_d = !RR;
        do_reset();
        i_cyc = 1; i_stb = 1; i_adr = 16'h1000;
        d_cyc = 1; d_stb = 1; d_adr = 16'h2000;
        @(negedge clk);
        m_ack = 1;
        #1;
        total++;
        if (m_adr !== (first_d ? 16'h2000 : 16'h1000)) begin
            bad++; $display("FAIL tie_first_adr: got %h want %h", m_adr, first_d ? 16'h2000 : 16'h1000);
        end
        total++;
        if (d_ack !== first_d || i_ack !== !first_d) begin
            bad++; $display("FAIL tie_first_ack: d_ack %b i_ack %b want %b %b", d_ack, i_ack, first_d, !first_d);
        end
        @(negedge clk);
        m_ack = 0;
        if (first_d) begin d_cyc = 0; d_stb = 0; end
        else begin i_cyc = 0; i_stb = 0; end
        #1;
        total++;
        if (m_cyc !== 1'b0) begin bad++; $display("FAIL tie_dead_cycle: m_cyc got %b want 0", m_cyc); end
        @(negedge clk);
        m_ack = 1;
        #1;
        total++;
        if (m_cyc !== 1'b1 || m_adr !== (first_d ? 16'h1000 : 16'h2000)) begin
            bad++; $display("FAIL tie_second_grant: m_cyc %b adr %h want 1 %h", m_cyc, m_adr, first_d ? 16'h1000 : 16'h2000);
        end
        total++;
        if (i_ack !== first_d || d_ack !== !first_d) begin
            bad++; $display("FAIL tie_second_ack: i_ack %b d_ack %b want %b %b", i_ack, d_ack, first_d, !first_d);
        end
        @(negedge clk);
        clr();
    endtask

    task automatic test_retry();
        logic [LINE_W-1:0] wb;
        wb = {4{32'hDEAD_BEEF}};
        do_reset();
        d_cyc = 1; d_stb = 1; d_we = 1; d_adr = 16'h4560; d_sel = 16'hFFFF; d_dat_w = wb;
        @(negedge clk); #1;
        total++;
        if (m_we !== 1'b1 || m_sel !== 16'hFFFF || m_adr !== 16'h4560 || m_dat_w !== wb) begin
            bad++; $display("FAIL retry_grant_fwd: we %b sel %h adr %h want 1 ffff 4560", m_we, m_sel, m_adr);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            m_ack = 1; m_retry = 1;
            #1;
            total++;
            if (d_retry !== 1'b1 || d_ack !== 1'b0 || m_cyc !== 1'b1) begin
                bad++; $display("FAIL retry_hold_%0d: d_retry %b d_ack %b m_cyc %b want 1 0 1", k, d_retry, d_ack, m_cyc);
            end
        end
        @(negedge clk);
        m_retry = 0; m_ack = 1;
        #1;
        total++;
        if (d_ack !== 1'b1 || d_retry !== 1'b0 || i_ack !== 1'b0) begin
            bad++; $display("FAIL retry_final_ack: d_ack %b d_retry %b i_ack %b want 1 0 0", d_ack, d_retry, i_ack);
        end
        @(negedge clk);
        clr();
        #1;
        total++;
        if (m_cyc !== 1'b0) begin bad++; $display("FAIL retry_idle: m_cyc got %b want 0", m_cyc); end
    endtask

    task automatic test_back_to_back();
        bit exp_d;
        do_reset();
        i_cyc = 1; i_stb = 1; i_adr = 16'h1111;
        @(negedge clk);
        m_ack = 1;
        #1;
        total++;
        if (i_ack !== 1'b1) begin bad++; $display("FAIL b2b_i_alone: i_ack got %b want 1", i_ack); end
        @(negedge clk);
        d_cyc = 1; d_stb = 1; d_adr = 16'h2222;
        #1;
        total++;
        if (m_cyc !== 1'b0) begin bad++; $display("FAIL b2b_idle_start: m_cyc got %b want 0", m_cyc); end
        for (int g = 0; g < 3; g++) begin
            exp_d = RR ? (g != 1) : 1'b1;
            @(negedge clk); #1;
            total++;
            if (m_adr !== (exp_d ? 16'h2222 : 16'h1111) || d_ack !== exp_d || i_ack !== !exp_d) begin
                bad++; $display("FAIL b2b_grant_%0d: adr %h d_ack %b i_ack %b want d=%b", g, m_adr, d_ack, i_ack, exp_d);
            end
            @(negedge clk); #1;
            total++;
            if (m_cyc !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
                bad++; $display("FAIL b2b_dead_%0d: m_cyc %b acks %b%b want 0 00", g, m_cyc, i_ack, d_ack);
            end
        end
        clr();
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_cyc = 1; d_stb = 1; d_adr = 16'h3000;
        @(negedge clk); #1;
        total++;
        if (m_cyc !== 1'b1 || m_adr !== 16'h3000) begin
            bad++; $display("FAIL rmid_grant: m_cyc %b adr %h want 1 3000", m_cyc, m_adr);
        end
        rst = 1;
        @(negedge clk);
        m_ack = 1;
        #1;
        total++;
        if (m_cyc !== 1'b0 || m_stb !== 1'b0 || d_ack !== 1'b0) begin
            bad++; $display("FAIL rmid_after: m_cyc %b m_stb %b d_ack %b want 0 0 0", m_cyc, m_stb, d_ack);
        end
        @(negedge clk);
        rst = 0; d_cyc = 0; d_stb = 0;
        #1;
        total++;
        if (m_cyc !== 1'b0 || d_ack !== 1'b0 || i_ack !== 1'b0) begin
            bad++; $display("FAIL rmid_idle: m_cyc %b d_ack %b i_ack %b want 0 0 0", m_cyc, d_ack, i_ack);
        end
        clr();
    endtask

    task automatic test_abort();
        do_reset();
        i_cyc = 1; i_stb = 1; i_adr = 16'h5000;
        @(negedge clk);
        d_cyc = 1; d_stb = 1; d_adr = 16'h6000;
        #1;
        total++;
        if (m_cyc !== 1'b1 || m_adr !== 16'h5000) begin
            bad++; $display("FAIL abort_grant_i: m_cyc %b adr %h want 1 5000", m_cyc, m_adr);
        end
        @(negedge clk);
        i_cyc = 0;
        #1;
        total++;
        if (m_cyc !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
            bad++; $display("FAIL abort_drop: m_cyc %b i_ack %b d_ack %b want 0 0 0", m_cyc, i_ack, d_ack);
        end
        @(negedge clk); #1;
        total++;
        if (m_cyc !== 1'b0) begin bad++; $display("FAIL abort_idle: m_cyc got %b want 0", m_cyc); end
        @(negedge clk);
        m_ack = 1;
        #1;
        total++;
        if (m_cyc !== 1'b1 || m_adr !== 16'h6000 || d_ack !== 1'b1 || i_ack !== 1'b0) begin
            bad++; $display("FAIL abort_grant_d: m_cyc %b adr %h d_ack %b i_ack %b want 1 6000 1 0", m_cyc, m_adr, d_ack, i_ack);
        end
        @(negedge clk);
        clr();
    endtask

    initial begin
        rst = 1'b1;
        clr();
        test_reset();
        test_single_read();
        test_tie();
        test_retry();
        test_back_to_back();
        test_reset_mid();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
